sync_fifo_stat: RTL
===================

Name: sync_fifo_stat

Overview:
- Parametrised synchronous FIFO; next generation of the UART buffer FIFO, placed between the UART receiver/transmitter and user logic.
- Adds configurable width/depth, an occupancy count, and programmable almost-full/almost-empty flags.
- Defines simultaneous read/write at the full and empty boundaries.
- Show-ahead read: the head word is always presented on rd_data while not empty.

Parameters:
- DATA_W, 8, bits per data word.
- ADDR_W, 7, address bits; DEPTH = 2**ADDR_W entries.
- AF_LEVEL, 2**ADDR_W-4, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write word.
- rd_en  in  1  read/pop request.
- rd_data  out  DATA_W  head word, combinational from memory at rd_addr.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- rd_addr  out  ADDR_W  current read pointer.
- wr_addr  out  ADDR_W  current write pointer.

Behaviour:
- Reset (reset_n low at a clk edge):
  - wr_addr = 0, rd_addr = 0, count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - Memory contents are not cleared.
  - Reset overrides any concurrent wr_en/rd_en.
  - Reset mid-stream discards all contents; the first write after reset lands at address 0.
- Accept logic (combinational):
  - wr_acc = wr_en & (~full | rd_en).
  - rd_acc = rd_en & ~empty.
- wr_acc: mem[wr_addr] <= wr_data; wr_addr <= wr_addr+1, mod DEPTH with natural wrap.
- rd_acc: rd_addr <= rd_addr+1, mod DEPTH.
- count update: count <= count + wr_acc - rd_acc, computed in ADDR_W+1 bits, never outside 0..DEPTH.
- Flags are registered and derived from the next count, so they update on the same edge as count (zero-cycle lag relative to count).
- Write latency: a word written at edge N appears on rd_data after edge N when the FIFO was empty; empty deasserts at edge N.
- Read latency: rd_data is valid combinationally whenever empty = 0; rd_acc at edge N presents the next word after edge N.
- Simultaneous wr_en & rd_en:
  - Normal (0 < count < DEPTH): both accepted; count unchanged; flags unchanged.
  - Empty: write accepted, read ignored; count becomes 1; empty deasserts.
  - Full: both accepted. The head word is read before the edge and its slot (wr_addr == rd_addr) is overwritten at the edge. count stays DEPTH; full stays 1.
- Write while full without rd_en: the word is dropped; no pointer or count change.
- Read while empty: ignored; no pointer or count change.

Optional Feature:
- Macro: SYNC_FIFO_ERR_EN.
- With the macro defined, add ports:
  - overflow  out  1, sticky; set by wr_en & full & ~rd_en.
  - underflow  out  1, sticky; set by rd_en & empty.
  - err_clr  in  1, clears both flags next edge.
  - If a set condition and err_clr coincide, set wins.
  - Both flags reset to 0.
- Without the macro: these ports and their logic are absent; drop behaviour is unchanged.

Decomposition:
- fifo_pkg holds:
  - depth/count-width helper constants (DEPTH = 2**ADDR_W, CNT_W = ADDR_W+1);
  - default threshold constants;
  - the parameter legality check, which fails elaboration if AF_LEVEL or AE_LEVEL is out of range.
- One sub-module: fifo_ram.
  - Simple dual-port memory, DATA_W x DEPTH.
  - Synchronous write, asynchronous read.
  - Ports: clk, we, waddr, wdata, raddr, rdata.
- Pointer, count and flag logic stays in sync_fifo_stat.

Test Plan:
- Reset → after reset_n low for 2 cycles: count=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_addr=wr_addr=0.
- Fill: DATA_W=8, ADDR_W=3 (DEPTH=8), AF_LEVEL=6, AE_LEVEL=1; write 0x10..0x17 →
  - almost_empty drops after the 2nd write;
  - almost_full rises after the 6th write;
  - full=1 and count=8 after the 8th write;
  - a 9th write of 0xFF is dropped and count stays 8.
- Drain, same configuration: 8 reads → rd_data sequence 0x10..0x17; empty=1 after the 8th read; a 9th read leaves rd_addr unchanged.
- Simultaneous read/write:
  - at count=8, write 0xAA with read → rd_data was 0x10, count=8, full=1, and 0xAA is last out;
  - at count=0, write 0x55 with read → count=1, rd_data=0x55.
- Wrap-around: stream 20 words with interleaved writes/reads keeping count between 2 and 5 → output order equals input order; rd_addr and wr_addr wrap from 7 to 0.
- SYNC_FIFO_ERR_EN:
  - write while full → overflow=1 and holds;
  - read while empty → underflow=1;
  - pulse err_clr → both flags 0 next cycle;
  - err_clr coinciding with a new overflow → overflow stays 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for sync_fifo_stat: size derivation, default
// thresholds, threshold legality check and the registered status-flag bundle.
package fifo_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 7;
  localparam int DEF_AE_LEVEL  = 4;
  localparam int DEF_AF_MARGIN = 4;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic int cnt_w_of(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic bit levels_legal(input int addr_w, input int af_level,
                                      input int ae_level);
    return (af_level >= 1) && (af_level <= depth_of(addr_w)) &&
           (ae_level >= 0) && (ae_level <= depth_of(addr_w) - 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for sync_fifo_stat: synchronous write port,
// asynchronous (combinational) read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [depth_of(ADDR_W)];

  // NOTE: storage has no reset; emptiness is tracked by the pointers and count,
  // and leaving the array unreset lets it map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/sync_fifo_stat.sv
// Show-ahead synchronous FIFO with occupancy count and registered programmable
// almost-full/almost-empty flags. Define SYNC_FIFO_ERR_EN for sticky overflow/underflow.
module sync_fifo_stat
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int AF_LEVEL = (2 ** ADDR_W) - DEF_AF_MARGIN,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr
`ifdef SYNC_FIFO_ERR_EN
  ,
  input  logic              err_clr,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam int CNT_W = cnt_w_of(ADDR_W);
  localparam logic [CNT_W-1:0]  C_DEPTH = CNT_W'(depth_of(ADDR_W));
  localparam logic [CNT_W-1:0]  C_AF    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0]  C_AE    = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0]  C_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] C_INC   = ADDR_W'(1);
  localparam fifo_flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1,
                                        almost_full: 1'b0, almost_empty: 1'b1};

  if (!levels_legal(ADDR_W, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
    $error("sync_fifo_stat: AF_LEVEL or AE_LEVEL outside legal range");
  end

  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  fifo_flags_t       r_flags;
  fifo_flags_t       w_flags_nxt;
  logic              w_wr_acc;
  logic              w_rd_acc;

  // A write into a full FIFO is legal when the head is popped on the same edge.
  assign w_wr_acc = wr_en & (~r_flags.full | rd_en);
  assign w_rd_acc = rd_en & ~r_flags.empty;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + C_ONE;
      2'b01:   w_count_nxt = r_count - C_ONE;
      default: w_count_nxt = r_count;
    endcase
    w_flags_nxt.full         = (w_count_nxt == C_DEPTH);
    w_flags_nxt.empty        = (w_count_nxt == '0);
    w_flags_nxt.almost_full  = (w_count_nxt >= C_AF);
    w_flags_nxt.almost_empty = (w_count_nxt <= C_AE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_count   <= '0;
      r_flags   <= FLAGS_RST;
    end else begin
      if (w_wr_acc) r_wr_addr <= r_wr_addr + C_INC;
      if (w_rd_acc) r_rd_addr <= r_rd_addr + C_INC;
      r_count <= w_count_nxt;
      r_flags <= w_flags_nxt;
    end
  end

  fifo_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (w_wr_acc),
    .waddr(r_wr_addr),
    .wdata(wr_data),
    .raddr(r_rd_addr),
    .rdata(rd_data)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;
  logic w_ovf_set;
  logic w_udf_set;

  assign w_ovf_set = wr_en & r_flags.full & ~rd_en;
  assign w_udf_set = rd_en & r_flags.empty;

  // A new error on the clearing edge stays visible.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_set | (r_overflow & ~err_clr);
      r_underflow <= w_udf_set | (r_underflow & ~err_clr);
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

  assign full         = r_flags.full;
  assign empty        = r_flags.empty;
  assign almost_full  = r_flags.almost_full;
  assign almost_empty = r_flags.almost_empty;
  assign count        = r_count;
  assign rd_addr      = r_rd_addr;
  assign wr_addr      = r_wr_addr;

endmodule
